// File: rtl/char_buf_scan_reader.sv
// Raster-order read master for the VGA character-buffer SRAM: fetches one 32-bit word,
// then streams its four character codes (lane 0 first) on a valid/ready interface.
module char_buf_scan_reader #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start,
  output logic [10:0] address2,
  output logic        chipselect2,
  output logic        clken2,
  output logic        write2,
  output logic [3:0]  byteenable2,
  output logic [31:0] writedata2,
  input  logic [31:0] readdata2,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        char_sop,
  output logic        char_eop,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    EMIT    = 2'd3
  } state_t;

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
  localparam logic       CONT     = CONTINUOUS;

  function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_sel = word[7:0];
      2'd1:    lane_sel = word[15:8];
      2'd2:    lane_sel = word[23:16];
      2'd3:    lane_sel = word[31:24];
      default: lane_sel = word[7:0];
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d, col_nx;
  logic [5:0]  row_q, row_d, row_nx;
  logic [31:0] word_q, word_d;
  logic [10:0] address2_q, address2_d;
  logic        chipselect2_q, chipselect2_d;
  logic        clken2_q, clken2_d;
  logic [7:0]  char_data_q, char_data_d;
  logic        char_valid_q, char_valid_d;
  logic        char_sop_q, char_sop_d;
  logic        char_eop_q, char_eop_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        restart_pending_q, restart_pending_d;
  logic        accept_s;
  logic        last_beat_s;

  // Next-state and registered-output decode for the scan FSM
  always_comb begin
    state_d           = state_q;
    col_d             = col_q;
    row_d             = row_q;
    word_d            = word_q;
    address2_d        = address2_q;
    chipselect2_d     = 1'b0;
    clken2_d          = 1'b0;
    char_data_d       = char_data_q;
    char_valid_d      = char_valid_q;
    char_sop_d        = char_sop_q;
    char_eop_d        = char_eop_q;
    busy_d            = busy_q;
    frame_done_d      = 1'b0;
    restart_pending_d = restart_pending_q;
    accept_s          = char_valid_q & char_ready;
    last_beat_s       = (row_q == ROW_LAST) && (col_q == COL_LAST);
    if (col_q == COL_LAST) begin
      col_nx = 7'd0;
      row_nx = row_q + 6'd1;
    end else begin
      col_nx = col_q + 7'd1;
      row_nx = row_q;
    end

    case (state_q)
      IDLE: begin
        if ((start | (CONT & restart_pending_q)) & enable) begin
          state_d           = ISSUE;
          col_d             = 7'd0;
          row_d             = 6'd0;
          busy_d            = 1'b1;
          chipselect2_d     = 1'b1;
          clken2_d          = 1'b1;
          address2_d        = 11'd0;
          restart_pending_d = 1'b0;
        end else if (!enable) begin
          restart_pending_d = 1'b0;
        end else begin
          restart_pending_d = restart_pending_q;
        end
      end
      ISSUE: begin
        state_d       = CAPTURE;
        chipselect2_d = 1'b1;
      end
      CAPTURE: begin
        state_d      = EMIT;
        word_d       = readdata2;
        char_valid_d = 1'b1;
        char_data_d  = lane_sel(readdata2, col_q[1:0]);
        char_sop_d   = (row_q == 6'd0) && (col_q == 7'd0);
        char_eop_d   = last_beat_s;
      end
      EMIT: begin
        if (accept_s && last_beat_s) begin
          state_d           = IDLE;
          col_d             = 7'd0;
          row_d             = 6'd0;
          char_valid_d      = 1'b0;
          char_sop_d        = 1'b0;
          char_eop_d        = 1'b0;
          busy_d            = 1'b0;
          frame_done_d      = 1'b1;
          restart_pending_d = CONT & enable;
        end else if (accept_s && (col_q[1:0] == 2'd3)) begin
          // Word exhausted: refetch; cols beyond COLS-1 are skipped by the row wrap
          state_d       = ISSUE;
          col_d         = col_nx;
          row_d         = row_nx;
          char_valid_d  = 1'b0;
          char_sop_d    = 1'b0;
          char_eop_d    = 1'b0;
          chipselect2_d = 1'b1;
          clken2_d      = 1'b1;
          address2_d    = {row_nx, col_nx[6:2]};
        end else if (accept_s) begin
          col_d       = col_nx;
          row_d       = row_nx;
          char_data_d = lane_sel(word_q, col_nx[1:0]);
          char_sop_d  = 1'b0;
          char_eop_d  = (row_nx == ROW_LAST) && (col_nx == COL_LAST);
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      col_q             <= 7'd0;
      row_q             <= 6'd0;
      word_q            <= 32'd0;
      address2_q        <= 11'd0;
      chipselect2_q     <= 1'b0;
      clken2_q          <= 1'b0;
      char_data_q       <= 8'd0;
      char_valid_q      <= 1'b0;
      char_sop_q        <= 1'b0;
      char_eop_q        <= 1'b0;
      busy_q            <= 1'b0;
      frame_done_q      <= 1'b0;
      restart_pending_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      col_q             <= col_d;
      row_q             <= row_d;
      word_q            <= word_d;
      address2_q        <= address2_d;
      chipselect2_q     <= chipselect2_d;
      clken2_q          <= clken2_d;
      char_data_q       <= char_data_d;
      char_valid_q      <= char_valid_d;
      char_sop_q        <= char_sop_d;
      char_eop_q        <= char_eop_d;
      busy_q            <= busy_d;
      frame_done_q      <= frame_done_d;
      restart_pending_q <= restart_pending_d;
    end
  end

  assign address2    = address2_q;
  assign chipselect2 = chipselect2_q;
  assign clken2      = clken2_q;
  assign write2      = 1'b0;
  assign byteenable2 = 4'hF;
  assign writedata2  = 32'd0;
  assign char_data   = char_data_q;
  assign char_valid  = char_valid_q;
  assign char_sop    = char_sop_q;
  assign char_eop    = char_eop_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_char_buf_scan_reader.sv
// Bench for char_buf_scan_reader: 80x60 one-shot instance plus a small continuous-mode instance,
// both fed by an SRAM model whose byte at (row,col) is ((row*128+col) & 0xFF) ^ salt.
module tb_char_buf_scan_reader;

  localparam int COLS    = 80;
  localparam int ROWS    = 60;
  localparam int BEATS   = COLS * ROWS;
  localparam int WORDS   = BEATS / 4;
  localparam int COLS_C  = 8;
  localparam int ROWS_C  = 3;
  localparam int BEATS_C = COLS_C * ROWS_C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, start, char_ready;
  logic [10:0] address2;
  logic        chipselect2, clken2, write2;
  logic [3:0]  byteenable2;
  logic [31:0] writedata2;
  logic [31:0] readdata2 = 32'd0;
  logic [7:0]  char_data;
  logic        char_valid, char_sop, char_eop, busy, frame_done;

  logic        enable_c, start_c, char_ready_c;
  logic [10:0] address2_c;
  logic        chipselect2_c, clken2_c, write2_c;
  logic [3:0]  byteenable2_c;
  logic [31:0] writedata2_c;
  logic [31:0] readdata2_c = 32'd0;
  logic [7:0]  char_data_c;
  logic        char_valid_c, char_sop_c, char_eop_c, busy_c, frame_done_c;

  logic [7:0]  salt = 8'd0;
  bit          rand_ready = 1'b0;
  int          n_checks = 0, n_fail = 0;
  int          beat_idx, word_idx, fd_cnt, beat_c = 0, fd_c = 0;
  bit          have_prev;
  logic [7:0]  prev_data;
  logic        prev_sop, prev_eop;

  char_buf_scan_reader #(.COLS(COLS), .ROWS(ROWS), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
    .address2(address2), .chipselect2(chipselect2), .clken2(clken2), .write2(write2),
    .byteenable2(byteenable2), .writedata2(writedata2), .readdata2(readdata2),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .char_sop(char_sop), .char_eop(char_eop), .busy(busy), .frame_done(frame_done)
  );

  char_buf_scan_reader #(.COLS(COLS_C), .ROWS(ROWS_C), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(enable_c), .start(start_c),
    .address2(address2_c), .chipselect2(chipselect2_c), .clken2(clken2_c), .write2(write2_c),
    .byteenable2(byteenable2_c), .writedata2(writedata2_c), .readdata2(readdata2_c),
    .char_data(char_data_c), .char_valid(char_valid_c), .char_ready(char_ready_c),
    .char_sop(char_sop_c), .char_eop(char_eop_c), .busy(busy_c), .frame_done(frame_done_c)
  );

  function automatic logic [31:0] sram_word(input logic [10:0] a, input logic [7:0] s);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(32'(a) * 4 + i) ^ s;
    return w;
  endfunction

  always @(posedge clk) begin
    if (chipselect2 && clken2) readdata2 <= sram_word(address2, salt);
    if (chipselect2_c && clken2_c) readdata2_c <= sram_word(address2_c, salt);
  end

  // Reference: the character at raster position idx, and the word address of the w-th fetch
  function automatic logic [7:0] exp_char(input int idx, input int cols);
    int r = idx / cols;
    int c = idx % cols;
    return 8'(r * 128 + c) ^ salt;
  endfunction

  function automatic logic [10:0] exp_addr(input int w, input int cols);
    int wpr = cols / 4;
    return 11'((w / wpr) * 32 + (w % wpr));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    beat_idx = 0; word_idx = 0; fd_cnt = 0; have_prev = 1'b0;
  endtask

  // One clock: observe both DUTs at the falling edge, then drive ready just after the rising edge
  task automatic step();
    @(negedge clk);
    if (reset_n) begin
      if (clken2) begin
        check("issue_addr", 32'(address2), 32'(exp_addr(word_idx, COLS)));
        check("addr_range", 32'(address2[4:0] < 5'd20 && address2[10:5] < 6'd60), 32'd1);
        check("write2", 32'(write2), 32'd0);
        word_idx++;
      end
      if (have_prev) begin
        check("stall_valid", 32'(char_valid), 32'd1);
        check("stall_data", 32'(char_data), 32'(prev_data));
        check("stall_sop", 32'(char_sop), 32'(prev_sop));
        check("stall_eop", 32'(char_eop), 32'(prev_eop));
        check("stall_clken", 32'(clken2), 32'd0);
      end
      if (char_valid && char_ready) begin
        check("data", 32'(char_data), 32'(exp_char(beat_idx, COLS)));
        check("sop", 32'(char_sop), 32'(beat_idx == 0));
        check("eop", 32'(char_eop), 32'(beat_idx == BEATS - 1));
        beat_idx++;
        have_prev = 1'b0;
      end else begin
        have_prev = char_valid;
        prev_data = char_data; prev_sop = char_sop; prev_eop = char_eop;
      end
      if (frame_done) fd_cnt++;
      if (char_valid_c && char_ready_c) begin
        check("c_data", 32'(char_data_c), 32'(exp_char(beat_c % BEATS_C, COLS_C)));
        check("c_sop", 32'(char_sop_c), 32'(beat_c % BEATS_C == 0));
        check("c_eop", 32'(char_eop_c), 32'(beat_c % BEATS_C == BEATS_C - 1));
        beat_c++;
      end
      if (frame_done_c) fd_c++;
    end
    @(posedge clk);
    #1;
    char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, 32'(char_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cs"}, 32'(chipselect2), 32'd0);
    check({tag, "_clken"}, 32'(clken2), 32'd0);
    check({tag, "_addr"}, 32'(address2), 32'd0);
    check({tag, "_data"}, 32'(char_data), 32'd0);
    check({tag, "_sop_eop"}, 32'({char_sop, char_eop}), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_be"}, 32'(byteenable2), 32'hF);
  endtask

  task automatic run_frame(input bit poke, input string tag);
    int cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (fd_cnt == 0 && cyc < 40000) begin
      start = poke && (cyc == 100 || cyc == 3000);
      step();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_timeout"}, 32'(fd_cnt != 0), 32'd1);
    repeat (20) step();
    check({tag, "_done_pulses"}, 32'(fd_cnt), 32'd1);
    check({tag, "_beats"}, 32'(beat_idx), 32'(BEATS));
    check({tag, "_words"}, 32'(word_idx), 32'(WORDS));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(char_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; enable = 1'b0; start = 1'b0; char_ready = 1'b1;
    enable_c = 1'b0; start_c = 1'b0; char_ready_c = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    reset_n = 1'b1;
    repeat (2) step();

    // enable low blocks a start
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("en_block_busy", 32'(busy), 32'd0);
    check("en_block_issue", 32'(word_idx), 32'd0);
    enable = 1'b1;

    // full frame at ready=1, then random backpressure, then start pulses while busy
    clear_mon(); run_frame(1'b0, "t1");
    salt = 8'($urandom); rand_ready = 1'b1;
    clear_mon(); run_frame(1'b0, "t2");
    rand_ready = 1'b0; salt = 8'($urandom);
    clear_mon(); run_frame(1'b1, "t3");

    // reset in the middle of a frame, then a clean frame
    salt = 8'($urandom); rand_ready = 1'b1;
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (beat_idx < 1000 && cyc < 20000) begin
      step();
      cyc++;
    end
    check("t5_reach_1000", 32'(beat_idx), 32'd1000);
    reset_n = 1'b0;
    #1;
    reset_checks("t5_async");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rand_ready = 1'b0;
    clear_mon(); run_frame(1'b0, "t5");

    // continuous mode: enable dropped during the second frame
    enable_c = 1'b1;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    cyc = 0;
    while (beat_c < BEATS_C + 10 && cyc < 2000) begin
      step();
      cyc++;
    end
    enable_c = 1'b0;
    cyc = 0;
    while (fd_c < 2 && cyc < 2000) begin
      step();
      cyc++;
    end
    repeat (100) step();
    check("t4_frames", 32'(fd_c), 32'd2);
    check("t4_beats", 32'(beat_c), 32'(2 * BEATS_C));
    check("t4_busy", 32'(busy_c), 32'd0);
    check("t4_valid", 32'(char_valid_c), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
